gate_truth_checker: RTL and testbench
=====================================

Name: gate_truth_checker

Overview:
- Self-checking sweep engine: the driving/checking side of a small combinational gate such as the team's 2-input AND gate.
- Drives every input vector onto the gate under test and samples the gate's output after a settle delay.
- Compares each sample against a parameterised truth table, then reports pass/fail, error count and first failing vector.
- Replaces hand-written stimulus benches; usable in simulation and on-chip BIST.

Parameters:
- N_IN, 2, number of gate inputs; 1..8.
- TRUTH, 4'b1000, expected output per vector; bit i is the expected y for input vector i. The default is AND. Width is 2**N_IN.
- SETTLE_CYC, 1, cycles each vector is held before sampling; >=1.
- CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request a sweep; sampled only in IDLE.
- dut_in  output  N_IN  vector driven to the gate inputs; bit0 = a, bit1 = b for a 2-input gate.
- dut_y  input  1  gate output y.
- busy  output  1  high while a sweep runs (SETTLE/CHECK states).
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  high when the last completed sweep had zero mismatches.
- err_count  output  CNT_W  mismatches in the current/last sweep; saturating.
- fail_valid  output  1  at least one mismatch recorded.
- first_fail_vec  output  N_IN  first mismatching vector; valid when fail_valid=1.

Behaviour:
- Reset (async, immediate, including mid-sweep): state=IDLE and all outputs 0. That is dut_in=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail_vec=0.
- The FSM has four states: IDLE, SETTLE, CHECK, DONE.
- IDLE, start=1 at an edge:
  - vec<=0, settle counter<=0.
  - err_count<=0, fail_valid<=0, first_fail_vec<=0, pass<=0.
  - Go to SETTLE; busy=1 from that edge.
- SETTLE: dut_in=vec held. The counter increments each cycle; after SETTLE_CYC cycles in SETTLE, go to CHECK.
- CHECK (one cycle): dut_in is still vec, and dut_y is compared with TRUTH[vec].
  - On mismatch: err_count increments, saturating at 2**CNT_W-1.
  - On the first mismatch only: fail_valid<=1 and first_fail_vec<=vec.
  - If vec == 2**N_IN-1, go to DONE.
  - Otherwise vec<=vec+1, the counter clears, and the FSM returns to SETTLE.
- DONE (one cycle): busy=0, done=1, pass<=(err_count==0 including the final CHECK result). Then go to IDLE.
- Hold after completion: pass, err_count, fail_valid and first_fail_vec keep their values until the next accepted start or reset. dut_in holds its last vector.
- Latency: each vector occupies SETTLE_CYC+1 cycles. done asserts 2**N_IN*(SETTLE_CYC+1)+1 edges after the start-accept edge. For the defaults that is 9.
- start while busy or in DONE is ignored; there is no queuing. start held high continuously re-launches a sweep on the first IDLE cycle after DONE.
- The vector counter wraps only via the DONE transition; vec never exceeds 2**N_IN-1.
- dut_y is treated as combinational from dut_in. Sampling occurs only in CHECK, never in SETTLE.

Test Plan:
- Correct AND gate connected, defaults, start pulse. Required response:
  - dut_in sequence 00,01,10,11, two cycles each.
  - done at edge 9 after start, with pass=1, err_count=0, fail_valid=0.
- dut_y stuck at 0 (AND defaults). Required response: err_count=1, fail_valid=1, first_fail_vec=2'b11, pass=0.
- dut_y stuck at 1. Required response: err_count=3, first_fail_vec=2'b00, pass=0.
- rst asserted while dut_in=2'b10 in SETTLE. Required response:
  - All outputs 0 immediately, without waiting for a clock edge; FSM in IDLE.
  - A subsequent start with a correct gate completes with pass=1.
- start pulsed during the sweep, then a second start after done, with a faulty first run. Required response:
  - The mid-sweep start has no effect.
  - The second start clears err_count/fail_valid at accept.
  - Results reflect only the second run.
- CNT_W=1, N_IN=2, TRUTH=4'b0110 against an AND gate (3 mismatches). Required response: err_count saturates at 1, first_fail_vec=2'b01, pass=0.

Source files
------------

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: sweeps every input vector of a small combinational gate,
// samples its output after a settle delay and compares it with a truth table.
// Reports pass/fail, a saturating mismatch count and the first failing vector.
//
// state  | meaning
// IDLE   | waiting for start; results of the last sweep held
// SETTLE | vector driven, waiting SETTLE_CYC cycles for the gate to settle
// CHECK  | gate output sampled and compared against TRUTH[vec]
// DONE   | sweep finished; pass latched and done pulsed on exit
module gate_truth_checker #(
    parameter int                    N_IN       = 2,
    parameter logic [(1<<N_IN)-1:0]  TRUTH      = 4'b1000,
    parameter int                    SETTLE_CYC = 1,
    parameter int                    CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   dut_in,
    input  logic              dut_y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic              fail_valid,
    output logic [N_IN-1:0]   first_fail_vec
);

    localparam int SW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);
    localparam logic [SW-1:0]    LAST_CNT = SW'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0]  LAST_VEC = {N_IN{1'b1}};
    localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_q;
    logic [N_IN-1:0]   vec_q;
    logic [SW-1:0]     cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [CNT_W-1:0]  err_q;
    logic              fail_q;
    logic [N_IN-1:0]   ffv_q;

    // Sweep sequencer; every output is a register so the gate sees clean levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= 1'b0;
            ffv_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        vec_q   <= '0;
                        cnt_q   <= '0;
                        err_q   <= '0;
                        fail_q  <= 1'b0;
                        ffv_q   <= '0;
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == LAST_CNT) begin
                        state_q <= CHECK;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CHECK: begin
                    if (dut_y != TRUTH[vec_q]) begin
                        if (err_q != ERR_MAX) begin
                            err_q <= err_q + 1'b1;
                        end
                        if (!fail_q) begin
                            fail_q <= 1'b1;
                            ffv_q  <= vec_q;
                        end
                    end
                    if (vec_q == LAST_VEC) begin
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        vec_q   <= vec_q + 1'b1;
                        cnt_q   <= '0;
                        state_q <= SETTLE;
                    end
                end
                DONE: begin
                    // err_q already includes the final CHECK result here.
                    done_q  <= 1'b1;
                    pass_q  <= (err_q == '0);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dut_in         = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign fail_valid     = fail_q;
    assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (default AND truth table, and a
// 1-bit counter with TRUTH=0110) driven by modelled gates, a per-cycle
// comparison against a sweep-level model, plus hand-computed literal checks.
module tb_gate_truth_checker;

    localparam int NV = 4;
    localparam int S  = 1;
    localparam int L  = NV * (S + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    int   mode = 0;  // gate on instance 0: 0 = AND, 1 = stuck 0, 2 = stuck 1

    logic [1:0] din0, din1, ffv0, ffv1;
    logic       y0, y1;
    logic       busy0, done0, pass0, fv0;
    logic       busy1, done1, pass1, fv1;
    logic [7:0] err0;
    logic [0:0] err1;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    assign y0 = (mode == 0) ? (din0[0] & din0[1]) : (mode == 1) ? 1'b0 : 1'b1;
    assign y1 = din1[0] & din1[1];

    gate_truth_checker u_dut (
        .clk(clk), .rst(rst), .start(start), .dut_in(din0), .dut_y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_valid(fv0), .first_fail_vec(ffv0)
    );

    gate_truth_checker #(.N_IN(2), .TRUTH(4'b0110), .SETTLE_CYC(1), .CNT_W(1)) u_sat (
        .clk(clk), .rst(rst), .start(start), .dut_in(din1), .dut_y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .first_fail_vec(ffv1)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Sweep-level model: a run is tracked by the edge count since accept.
    logic [3:0] m_truth [2] = '{4'b1000, 4'b0110};
    int         m_max   [2] = '{255, 1};
    logic       m_run [2] = '{0, 0};
    int         m_t   [2] = '{0, 0};
    logic       m_busy[2] = '{0, 0};
    logic       m_done[2] = '{0, 0};
    logic       m_pass[2] = '{0, 0};
    logic       m_fv  [2] = '{0, 0};
    int         m_err [2] = '{0, 0};
    int         m_ffv [2] = '{0, 0};
    int         m_in  [2] = '{0, 0};

    function automatic logic gate_y(input int inst, input int v);
        logic a, b;
        a = v[0];
        b = v[1];
        if (inst == 1 || mode == 0) return a & b;
        return (mode == 2);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_run[i] <= 0; m_t[i] <= 0; m_busy[i] <= 0; m_done[i] <= 0;
                m_pass[i] <= 0; m_fv[i] <= 0; m_err[i] <= 0; m_ffv[i] <= 0;
                m_in[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int t, e, f, v;
                logic fv;
                if (!m_run[i]) begin
                    m_done[i] <= 0;
                    if (start) begin
                        m_run[i] <= 1; m_t[i] <= 0; m_busy[i] <= 1; m_in[i] <= 0;
                        m_err[i] <= 0; m_fv[i] <= 0; m_ffv[i] <= 0; m_pass[i] <= 0;
                    end
                end else begin
                    t  = m_t[i] + 1;
                    e  = m_err[i];
                    fv = m_fv[i];
                    f  = m_ffv[i];
                    if (t % (S + 1) == 0 && t <= L) begin
                        v = t / (S + 1) - 1;
                        if (gate_y(i, v) != m_truth[i][v]) begin
                            if (e < m_max[i]) e++;
                            if (!fv) begin fv = 1; f = v; end
                        end
                    end
                    m_t[i]    <= t;
                    m_err[i]  <= e;
                    m_fv[i]   <= fv;
                    m_ffv[i]  <= f;
                    m_in[i]   <= (t / (S + 1) > NV - 1) ? NV - 1 : t / (S + 1);
                    m_busy[i] <= (t < L);
                    if (t == L + 1) begin
                        m_done[i] <= 1;
                        m_pass[i] <= (e == 0);
                        m_run[i]  <= 0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("busy0", busy0, m_busy[0]);   chk("busy1", busy1, m_busy[1]);
        chk("done0", done0, m_done[0]);   chk("done1", done1, m_done[1]);
        chk("pass0", pass0, m_pass[0]);   chk("pass1", pass1, m_pass[1]);
        chk("err0", err0, m_err[0]);      chk("err1", err1, m_err[1]);
        chk("fv0", fv0, m_fv[0]);         chk("fv1", fv1, m_fv[1]);
        chk("ffv0", ffv0, m_ffv[0]);      chk("ffv1", ffv1, m_ffv[1]);
        chk("din0", din0, m_in[0]);       chk("din1", din1, m_in[1]);
    end

    // Launch a sweep, return edges from accept to done and the first 8 vectors.
    task automatic run_sweep(input int m, input bit mid_start, output int n,
                             output logic [15:0] seq);
        @(posedge clk); #1;
        mode  = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seq = {14'b0, din0};
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (n < 8) seq = {seq[13:0], din0};
            if (mid_start && n == 3) start = 1'b1;
            if (mid_start && n == 4) start = 1'b0;
            if (done0) break;
        end
        if (n >= 40) chk("done_timeout", 0, 1);
    endtask

    int          n;
    logic [15:0] seq;

    initial begin
        #1 rst = 1'b1;
        #20;
        chk("rst_busy", busy0, 0);  chk("rst_done", done0, 0);
        chk("rst_err", err0, 0);    chk("rst_din", din0, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Correct AND gate.
        run_sweep(0, 0, n, seq);
        chk("and_latency", n, 9);
        chk("and_seq", seq, 16'h05AF);
        chk("and_pass", pass0, 1);  chk("and_err", err0, 0);  chk("and_fv", fv0, 0);
        chk("sat_err", err1, 1);    chk("sat_ffv", ffv1, 1);
        chk("sat_fv", fv1, 1);      chk("sat_pass", pass1, 0);

        // Stuck at 0.
        run_sweep(1, 0, n, seq);
        chk("s0_err", err0, 1);  chk("s0_fv", fv0, 1);
        chk("s0_ffv", ffv0, 3);  chk("s0_pass", pass0, 0);

        // Stuck at 1.
        run_sweep(2, 0, n, seq);
        chk("s1_err", err0, 3);  chk("s1_ffv", ffv0, 0);  chk("s1_pass", pass0, 0);

        // Faulty run with a start pulse mid-sweep, then a clean rerun.
        run_sweep(2, 1, n, seq);
        chk("mid_latency", n, 9);
        chk("mid_err", err0, 3);
        repeat (2) @(posedge clk);
        #1 chk("hold_err", err0, 3);  chk("hold_ffv", ffv0, 0);
        @(posedge clk); #1;
        mode  = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("accept_err_clr", err0, 0);
        chk("accept_fv_clr", fv0, 0);
        n = 0;
        while (n < 40 && !done0) begin @(posedge clk); n++; #1; end
        chk("rerun_latency", n, 9);
        chk("rerun_pass", pass0, 1);  chk("rerun_err", err0, 0);

        // Asynchronous reset while vector 2 is settling.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("pre_rst_din", din0, 2);
        chk("pre_rst_busy", busy0, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_din", din0, 0);   chk("arst_busy", busy0, 0);
        chk("arst_done", done0, 0); chk("arst_err", err0, 0);
        chk("arst_fv", fv0, 0);     chk("arst_ffv", ffv0, 0);
        chk("arst_pass", pass0, 0);
        @(posedge clk); #1 rst = 1'b0;
        run_sweep(0, 0, n, seq);
        chk("post_rst_latency", n, 9);
        chk("post_rst_pass", pass0, 1);

        repeat (3) @(posedge clk);
        #1 $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
